// File: rtl/module_bus_io_interface_pkg.sv
// Address map, register layout and address decode helper for the data-side bus stage.
package pkg_bus_map;

    localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR      = 32'h0000_2000;
    localparam logic [31:0] SW_ADDR       = 32'h0000_2004;
    localparam logic [31:0] BTN_ADDR      = 32'h0000_2008;
    localparam logic [31:0] TCOUNT_ADDR   = 32'h0000_200C;
    localparam logic [31:0] TCMP_ADDR     = 32'h0000_2010;
    localparam logic [31:0] TCTRL_ADDR    = 32'h0000_2014;
    localparam logic [31:0] SEG_ADDR      = 32'h0000_2018;

    localparam int unsigned TCTRL_EN_BIT         = 32'd0;
    localparam int unsigned TCTRL_MATCH_BIT      = 32'd1;
    localparam int unsigned TCTRL_AUTORELOAD_BIT = 32'd2;
    localparam int unsigned TCTRL_IRQ_EN_BIT     = 32'd3;

    localparam int unsigned LED_W = 32'd16;
    localparam int unsigned SW_W  = 32'd16;
    localparam int unsigned SEG_W = 32'd16;

    typedef enum logic [3:0] {
        SEL_NONE   = 4'd0,
        SEL_RAM    = 4'd1,
        SEL_LED    = 4'd2,
        SEL_SW     = 4'd3,
        SEL_BTN    = 4'd4,
        SEL_TCOUNT = 4'd5,
        SEL_TCMP   = 4'd6,
        SEL_TCTRL  = 4'd7,
        SEL_SEG    = 4'd8
    } periph_sel_e;

    // RAM wins over the peripheral window; misaligned peripheral addresses select nothing.
    function automatic periph_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
        periph_sel_e sel;
        if ((addr - RAM_BASE_ADDR) < ram_bytes) begin
            sel = SEL_RAM;
        end else if (addr[1:0] != 2'b00) begin
            sel = SEL_NONE;
        end else begin
            case (addr)
                LED_ADDR:    sel = SEL_LED;
                SW_ADDR:     sel = SEL_SW;
                BTN_ADDR:    sel = SEL_BTN;
                TCOUNT_ADDR: sel = SEL_TCOUNT;
                TCMP_ADDR:   sel = SEL_TCMP;
                TCTRL_ADDR:  sel = SEL_TCTRL;
                SEG_ADDR:    sel = SEL_SEG;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/module_bus_io_interface_if.sv
// Processor data-side bus: store strobe, byte address, store data and load data.
interface module_bus_io_interface_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output addr, output writedata, input readdata);
    modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface

// File: rtl/module_bus_io_interface_timer.sv
// 32-bit timer: prescaler, free-running counter, compare with optional autoreload, sticky match flag.
module module_timer
    import pkg_bus_map::*;
#(
    parameter int unsigned PRESCALE = 32'd10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic        autoreload,
    input  logic [31:0] cmp_value,
    input  logic        match_clr,
    output logic [31:0] count,
    output logic        match
);

    localparam int unsigned     PS_W    = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 32'd1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(32'd1);

    logic [PS_W-1:0] presc_r;
    logic [31:0]     count_r;
    logic            match_r;
    logic            tick_s;
    logic            hit_s;

    assign tick_s = en & (presc_r == PS_LAST);
    // cmp_value is the register output, so a same-cycle TCMP write does not affect this compare
    assign hit_s  = tick_s & (count_r == cmp_value);
    assign count  = count_r;
    assign match  = match_r;

    // Prescaler: advances only while enabled, holds its phase when disabled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PS_W{1'b0}};
        end else if (en) begin
            presc_r <= presc_r + PS_ONE;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Counter: wraps silently at all-ones; restarts from zero on a match when autoreload is set.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_r <= 32'd0;
        end else if (hit_s && autoreload) begin
            count_r <= 32'd0;
        end else if (tick_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Match flag: a new match beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            match_r <= 1'b0;
        end else if (hit_s) begin
            match_r <= 1'b1;
        end else if (match_clr) begin
            match_r <= 1'b0;
        end else begin
            match_r <= match_r;
        end
    end

endmodule

// File: rtl/module_bus_io_interface.sv
// Data-side bus stage: decodes processor loads/stores to data RAM or memory-mapped LED, switch,
// button, 7-segment and timer registers; load data is combinational from registered state.
module module_bus_io_interface
    import pkg_bus_map::*;
#(
    parameter int unsigned RAM_DEPTH   = 32'd1024,
    parameter int unsigned PRESCALE    = 32'd10,
    parameter int unsigned SYNC_STAGES = 32'd2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    module_bus_io_interface_if.slave     bus,
    output logic                         ram_we_o,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
    output logic [31:0]                  ram_wdata_o,
    input  logic [31:0]                  ram_rdata_i,
    input  logic [SW_W-1:0]              sw_i,
    input  logic                         btn_i,
    output logic [LED_W-1:0]             led_o,
    output logic [SEG_W-1:0]             seg_data_o,
    output logic                         irq_o
);

    localparam int unsigned AW        = $clog2(RAM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 32'd4);

    periph_sel_e                     sel_s;
    logic                            wr_led_s, wr_btn_s, wr_tcmp_s, wr_tctrl_s, wr_seg_s;
    logic                            match_clr_s, btn_rise_s, match_s;
    logic [31:0]                     tcount_s;
    logic [31:0]                     rdata_s;
    logic [LED_W-1:0]                led_r;
    logic [SEG_W-1:0]                seg_r;
    logic [31:0]                     tcmp_r;
    logic                            tctrl_en_r, tctrl_ar_r, tctrl_irq_en_r;
    logic                            btn_flag_r, btn_prev_r, irq_r;
    logic [SYNC_STAGES-1:0]          btn_sync_r;
    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_r;

    assign sel_s       = decode_addr(bus.addr, RAM_BYTES);
    assign wr_led_s    = bus.memwrite & (sel_s == SEL_LED);
    assign wr_btn_s    = bus.memwrite & (sel_s == SEL_BTN);
    assign wr_tcmp_s   = bus.memwrite & (sel_s == SEL_TCMP);
    assign wr_tctrl_s  = bus.memwrite & (sel_s == SEL_TCTRL);
    assign wr_seg_s    = bus.memwrite & (sel_s == SEL_SEG);
    assign match_clr_s = wr_tctrl_s & bus.writedata[TCTRL_MATCH_BIT];
    assign btn_rise_s  = btn_sync_r[SYNC_STAGES-1] & ~btn_prev_r;

    assign ram_we_o    = bus.memwrite & (sel_s == SEL_RAM);
    assign ram_addr_o  = bus.addr[AW+1:2];
    assign ram_wdata_o = bus.writedata;

    assign led_o       = led_r;
    assign seg_data_o  = seg_r;
    assign irq_o       = irq_r;
    assign bus.readdata = rdata_s;

    // Synchronizers for the asynchronous switch and button inputs, plus button edge history.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sw_sync_r  <= {(SYNC_STAGES*SW_W){1'b0}};
            btn_sync_r <= {SYNC_STAGES{1'b0}};
            btn_prev_r <= 1'b0;
        end else begin
            sw_sync_r  <= {sw_sync_r[SYNC_STAGES-2:0], sw_i};
            btn_sync_r <= {btn_sync_r[SYNC_STAGES-2:0], btn_i};
            btn_prev_r <= btn_sync_r[SYNC_STAGES-1];
        end
    end

    // Writable peripheral registers; a button edge wins over a same-cycle W1C.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            led_r          <= {LED_W{1'b0}};
            seg_r          <= {SEG_W{1'b0}};
            tcmp_r         <= 32'd0;
            tctrl_en_r     <= 1'b0;
            tctrl_ar_r     <= 1'b0;
            tctrl_irq_en_r <= 1'b0;
            btn_flag_r     <= 1'b0;
        end else begin
            if (wr_led_s) led_r <= bus.writedata[LED_W-1:0];
            if (wr_seg_s) seg_r <= bus.writedata[SEG_W-1:0];
            if (wr_tcmp_s) tcmp_r <= bus.writedata;
            if (wr_tctrl_s) begin
                tctrl_en_r     <= bus.writedata[TCTRL_EN_BIT];
                tctrl_ar_r     <= bus.writedata[TCTRL_AUTORELOAD_BIT];
                tctrl_irq_en_r <= bus.writedata[TCTRL_IRQ_EN_BIT];
            end
            if (btn_rise_s) begin
                btn_flag_r <= 1'b1;
            end else if (wr_btn_s && bus.writedata[0]) begin
                btn_flag_r <= 1'b0;
            end else begin
                btn_flag_r <= btn_flag_r;
            end
        end
    end

    // Interrupt output registered from the match flag gated by irq_en.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= match_s & tctrl_irq_en_r;
        end
    end

    module_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en         (tctrl_en_r),
        .autoreload (tctrl_ar_r),
        .cmp_value  (tcmp_r),
        .match_clr  (match_clr_s),
        .count      (tcount_s),
        .match      (match_s)
    );

    // Load data mux; unmapped or misaligned peripheral addresses read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_RAM:    rdata_s = ram_rdata_i;
            SEL_LED:    rdata_s = {{(32-LED_W){1'b0}}, led_r};
            SEL_SW:     rdata_s = {{(32-SW_W){1'b0}}, sw_sync_r[SYNC_STAGES-1]};
            SEL_BTN:    rdata_s = {31'd0, btn_flag_r};
            SEL_TCOUNT: rdata_s = tcount_s;
            SEL_TCMP:   rdata_s = tcmp_r;
            SEL_TCTRL:  rdata_s = {28'd0, tctrl_irq_en_r, tctrl_ar_r, match_s, tctrl_en_r};
            SEL_SEG:    rdata_s = {{(32-SEG_W){1'b0}}, seg_r};
            default:    rdata_s = 32'd0;
        endcase
    end

endmodule
